// File: rtl/atten_dac_serial_sequencer.sv
// atten_dac_serial_sequencer
// Queues host writes of {chip, A/B select, 8-bit factor} and shifts each one
// MSB-first into the 74HC164 in front of the AD7528 pair. A chip-select strobe
// then latches the byte, with datadac selecting DAC A or B.
// Optional feature macro: ATTEN_SKIP_UNCHANGED_EN. When it is defined, a write
// whose value equals the value last sent to the same {chip, A/B} is retired
// without serial activity.
module atten_dac_serial_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HALF_PERIOD = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic                          wr_right,
  input  logic                          wr_sel_a,
  input  logic [7:0]                    wr_value,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          datadac,
  output logic                          clkdac,
  output logic                          csdac1n,
  output logic                          csdac2n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(HALF_PERIOD);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PH_LAST    = PW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_SEL,
    S_STROBE,
    S_RELEASE
  } state_t;

  // FIFO storage: {right, sel_a, value}
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;

  state_t        r_state;
  logic [PW-1:0] r_phase_cnt;
  logic [2:0]    r_bit_idx;
  logic          r_cur_right;
  logic          r_cur_sel_a;
  logic [7:0]    r_cur_value;

  logic          w_push;
  logic          w_pop;
  logic          w_phase_done;
  logic [9:0]    w_head;
  logic          w_head_right;
  logic          w_head_sel_a;
  logic [7:0]    w_head_value;
  logic          w_skip;

  assign wr_ready     = (r_count != FULL_LEVEL);
  assign w_push       = wr_valid && wr_ready;
  assign w_pop        = (r_state == S_LOAD);
  assign fifo_level   = r_count;
  assign busy         = (r_state != S_IDLE) || (r_count != '0);
  assign w_phase_done = (r_phase_cnt == PH_LAST);

  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_right = w_head[9];
  assign w_head_sel_a = w_head[8];
  assign w_head_value = w_head[7:0];

  // FIFO write port; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {wr_right, wr_sel_a, wr_value};
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the level unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ATTEN_SKIP_UNCHANGED_EN
  // One shadow slot per {chip, A/B}; a slot is written as RELEASE is entered
  logic [3:0] w_hit;
  logic       w_shadow_wr;
  logic [1:0] w_cur_key;
  logic [1:0] w_head_key;

  assign w_shadow_wr = (r_state == S_STROBE) && w_phase_done;
  assign w_cur_key   = {r_cur_right, r_cur_sel_a};
  assign w_head_key  = {w_head_right, w_head_sel_a};
  assign w_skip      = |w_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_shadow
      logic [7:0] r_shadow_val;
      logic       r_shadow_vld;

      // Record the factor the DAC now holds for this {chip, A/B}
      always_ff @(posedge clk) begin
        if (reset) begin
          r_shadow_val <= '0;
          r_shadow_vld <= 1'b0;
        end else if (w_shadow_wr && (w_cur_key == 2'(gi))) begin
          r_shadow_val <= r_cur_value;
          r_shadow_vld <= 1'b1;
        end
      end

      assign w_hit[gi] = r_shadow_vld && (w_head_key == 2'(gi)) &&
                         (r_shadow_val == w_head_value);
    end
  endgenerate
`else
  assign w_skip = 1'b0;
`endif

  // Serial FSM; outputs are registered and change together with the state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phase_cnt <= '0;
      r_bit_idx   <= 3'd7;
      r_cur_right <= 1'b0;
      r_cur_sel_a <= 1'b0;
      r_cur_value <= '0;
      datadac     <= 1'b0;
      clkdac      <= 1'b0;
      csdac1n     <= 1'b1;
      csdac2n     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_phase_cnt <= '0;
          if (r_count != '0) begin
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_cur_right <= w_head_right;
          r_cur_sel_a <= w_head_sel_a;
          r_cur_value <= w_head_value;
          r_bit_idx   <= 3'd7;
          r_phase_cnt <= '0;
          if (w_skip) begin
            // Duplicate of what the DAC already holds: retire in this cycle
            r_state <= (r_count != LW'(1)) ? S_LOAD : S_IDLE;
          end else begin
            r_state <= S_SHIFT_LO;
            clkdac  <= 1'b0;
            datadac <= w_head_value[7];
          end
        end

        S_SHIFT_LO: begin
          if (w_phase_done) begin
            r_phase_cnt <= '0;
            r_state     <= S_SHIFT_HI;
            clkdac      <= 1'b1;
          end else begin
            r_phase_cnt <= r_phase_cnt + PW'(1);
          end
        end

        S_SHIFT_HI: begin
          if (w_phase_done) begin
            r_phase_cnt <= '0;
            clkdac      <= 1'b0;
            if (r_bit_idx == 3'd0) begin
              r_state <= S_SEL;
              datadac <= r_cur_sel_a;
            end else begin
              r_state   <= S_SHIFT_LO;
              r_bit_idx <= r_bit_idx - 3'd1;
              datadac   <= r_cur_value[r_bit_idx - 3'd1];
            end
          end else begin
            r_phase_cnt <= r_phase_cnt + PW'(1);
          end
        end

        S_SEL: begin
          if (w_phase_done) begin
            r_phase_cnt <= '0;
            r_state     <= S_STROBE;
            csdac1n     <= r_cur_right;
            csdac2n     <= ~r_cur_right;
          end else begin
            r_phase_cnt <= r_phase_cnt + PW'(1);
          end
        end

        S_STROBE: begin
          if (w_phase_done) begin
            r_phase_cnt <= '0;
            r_state     <= S_RELEASE;
            csdac1n     <= 1'b1;
            csdac2n     <= 1'b1;
          end else begin
            r_phase_cnt <= r_phase_cnt + PW'(1);
          end
        end

        S_RELEASE: begin
          if (w_phase_done) begin
            r_phase_cnt <= '0;
            datadac     <= 1'b0;
            r_state     <= (r_count != '0) ? S_LOAD : S_IDLE;
          end else begin
            r_phase_cnt <= r_phase_cnt + PW'(1);
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_phase_cnt <= '0;
          datadac     <= 1'b0;
          clkdac      <= 1'b0;
          csdac1n     <= 1'b1;
          csdac2n     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atten_dac_serial_sequencer.sv
// Testbench for atten_dac_serial_sequencer: directed steps plus randomized
// writes, checked against a transaction-level model of the queue, the
// optional duplicate suppression and the 74HC164 + AD7528 receiver.
module tb_atten_dac_serial_sequencer;

  localparam int FD = 4;
  localparam int HP = 2;
  localparam int LW = $clog2(FD) + 1;
  localparam int XFER_BUSY = 2 + 19 * HP;  // one queued sample + LOAD + 19 phases
  localparam int SKIP_BUSY = 2;            // one queued sample + LOAD

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          wr_right = 1'b0;
  logic          wr_sel_a = 1'b0;
  logic [7:0]    wr_value = '0;
  logic [LW-1:0] fifo_level;
  logic          busy;
  logic          datadac;
  logic          clkdac;
  logic          csdac1n;
  logic          csdac2n;

  always #5 clk = ~clk;

  atten_dac_serial_sequencer #(.FIFO_DEPTH(FD), .HALF_PERIOD(HP)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_right(wr_right), .wr_sel_a(wr_sel_a), .wr_value(wr_value),
    .fifo_level(fifo_level), .busy(busy), .datadac(datadac), .clkdac(clkdac),
    .csdac1n(csdac1n), .csdac2n(csdac2n)
  );

  typedef struct packed {
    logic       right;
    logic       sel_a;
    logic [7:0] value;
  } entry_t;

  int         checks = 0;
  int         failures = 0;
  entry_t     exp_q[$];
  logic [7:0] m_shadow[4];
  bit         m_valid[4];
  logic [7:0] m_factor[4];
  logic [7:0] rx_factor[4];
  bit         last_skip;
  int         mon_rises = 0;
  logic [7:0] mon_shreg = '0;
  int         pulses1 = 0;
  int         pulses2 = 0;
  logic       p_clk = 1'b0;
  logic       p_cs1 = 1'b1;
  logic       p_cs2 = 1'b1;

  function automatic logic [7:0] rx_scale(input logic [7:0] v);
    logic [11:0] p;
    p = {4'b0, v} * 12'd9;
    return p[11:4];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver model: a cs falling edge retires the oldest expected transfer
  task automatic strobe(input bit right);
    entry_t e;
    logic [1:0] idx;
    if (right) pulses2++; else pulses1++;
    check("bits_per_xfer", mon_rises, 8);
    check("strobe_expected", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("xfer_chip", right, e.right);
      check("xfer_sel", datadac, e.sel_a);
      check("xfer_value", mon_shreg, e.value);
      m_factor[{e.right, e.sel_a}] = rx_scale(e.value);
    end
    idx = {right, datadac};
    rx_factor[idx] = rx_scale(mon_shreg);
    mon_rises = 0;
  endtask

  // Serial line monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (reset) begin
      mon_rises = 0;
    end else begin
      if (!p_clk && clkdac) begin
        mon_shreg = {mon_shreg[6:0], datadac};
        mon_rises++;
      end
      if (!csdac1n || !csdac2n) begin
        check("clk_low_in_cs", clkdac, 0);
        check("single_cs", (csdac1n | csdac2n), 1);
      end
      if (p_cs1 && !csdac1n) strobe(1'b0);
      if (p_cs2 && !csdac2n) strobe(1'b1);
    end
    p_clk = clkdac;
    p_cs1 = csdac1n;
    p_cs2 = csdac2n;
  end

  // Transaction-level model of acceptance and duplicate suppression
  task automatic model_accept(input logic r, input logic a, input logic [7:0] v);
    logic [1:0] idx;
    bit skip;
    idx = {r, a};
`ifdef ATTEN_SKIP_UNCHANGED_EN
    skip = m_valid[idx] && (m_shadow[idx] == v);
`else
    skip = 1'b0;
`endif
    if (!skip) begin
      exp_q.push_back({r, a, v});
      m_shadow[idx] = v;
      m_valid[idx] = 1'b1;
    end
    last_skip = skip;
  endtask

  // Present a write at a negedge and hold it until accepted; returns at the
  // negedge right after the accepting posedge with wr_valid still high
  task automatic push(input logic r, input logic a, input logic [7:0] v, output int waited);
    waited = 0;
    wr_valid = 1'b1;
    wr_right = r;
    wr_sel_a = a;
    wr_value = v;
    while (!wr_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("push_ready", wr_ready, 1);
    @(negedge clk);
    model_accept(r, a, v);
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_busy", busy, 0);
    check("rst_datadac", datadac, 0);
    check("rst_clkdac", clkdac, 0);
    check("rst_csdac1n", csdac1n, 1);
    check("rst_csdac2n", csdac2n, 1);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
  endtask

  initial begin
    int n;
    int w;
    int p0;
    int total;
    logic [7:0] v;
    logic r;
    logic a;
    logic [7:0] pool[4];

    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = '0;
      m_valid[i] = 1'b0;
      m_factor[i] = '0;
      rx_factor[i] = '0;
    end

    // Step 1: left chip, DAC A, 0xA5
    do_reset();
    push(1'b0, 1'b1, 8'hA5, w);
    wr_valid = 1'b0;
    measure_busy(n);
    check("t1_busy_len", n, XFER_BUSY);
    check("t1_factor_left_a", rx_factor[1], 8'h5C);
    check("t1_pulses1", pulses1, 1);
    check("t1_pulses2", pulses2, 0);
    $display("step1 write left A 0xA5 busy=%0d", n);

    // Step 2: right chip, DAC B, 0x3C
    p0 = pulses2;
    push(1'b1, 1'b0, 8'h3C, w);
    wr_valid = 1'b0;
    measure_busy(n);
    check("t2_busy_len", n, XFER_BUSY);
    check("t2_factor_right_b", rx_factor[2], 8'h21);
    check("t2_pulses2", pulses2 - p0, 1);
    $display("step2 write right B 0x3C busy=%0d", n);

    // Step 3: five back-to-back writes, none of them duplicates
    p0 = pulses1 + pulses2;
    for (int i = 0; i < 5; i++) begin
      r = 1'($urandom_range(0, 1));
      a = 1'($urandom_range(0, 1));
      v = 8'($urandom);
      if (m_valid[{r, a}] && m_shadow[{r, a}] == v) v = v ^ 8'h01;
      push(r, a, v, w);
      $display("step3 burst write %0d right=%0d sel_a=%0d value=%02h", i, r, a, v);
    end
    wr_valid = 1'b0;
    check("t3_full_ready", wr_ready, 0);
    check("t3_full_level", fifo_level, FD);
    measure_busy(n);
    total = n + 4;
    check("t3_busy_len", total, 1 + 5 * (1 + 19 * HP));
    check("t3_level_empty", fifo_level, 0);
    check("t3_queue_drained", exp_q.size(), 0);
    check("t3_pulses", pulses1 + pulses2 - p0, 5);

    // Step 4: reset in the 4th SHIFT_HI
    push(1'b0, 1'b0, 8'h33, w);
    wr_valid = 1'b0;
    measure_busy(n);
    check("t4_pre_factor", rx_factor[0], 8'h1C);
    p0 = pulses1 + pulses2;
    push(1'b0, 1'b0, 8'h77, w);
    push(1'b0, 1'b0, 8'h11, w);
    wr_valid = 1'b0;
    n = 0;
    while (mon_rises != 4 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t4_reach_rise4", mon_rises, 4);
    check("t4_level_before", fifo_level, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t4_clkdac", clkdac, 0);
    check("t4_csdac1n", csdac1n, 1);
    check("t4_csdac2n", csdac2n, 1);
    check("t4_level", fifo_level, 0);
    check("t4_busy", busy, 0);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    repeat (60) @(negedge clk);
    check("t4_no_strobe", pulses1 + pulses2 - p0, 0);
    check("t4_factor_kept", rx_factor[0], 8'h1C);
    check("t4_idle", busy, 0);
    $display("step4 reset mid-transfer factor=%02h", rx_factor[0]);

    // Steps 5/6: duplicate write, then a changed value
    do_reset();
    p0 = pulses1;
    push(1'b0, 1'b1, 8'h80, w);
    wr_valid = 1'b0;
    measure_busy(n);
    check("t5_first_busy", n, XFER_BUSY);
    push(1'b0, 1'b1, 8'h80, w);
    wr_valid = 1'b0;
    measure_busy(n);
`ifdef ATTEN_SKIP_UNCHANGED_EN
    check("t5_dup_busy", n, SKIP_BUSY);
`else
    check("t5_dup_busy", n, XFER_BUSY);
`endif
    push(1'b0, 1'b1, 8'h81, w);
    wr_valid = 1'b0;
    measure_busy(n);
    check("t5_third_busy", n, XFER_BUSY);
`ifdef ATTEN_SKIP_UNCHANGED_EN
    check("t5_pulses1", pulses1 - p0, 2);
`else
    check("t5_pulses1", pulses1 - p0, 3);
`endif
    check("t5_factor", rx_factor[1], rx_scale(8'h81));
    $display("step5 duplicate sequence pulses=%0d", pulses1 - p0);

    // Randomized isolated writes drawn from a small value pool
    pool[0] = 8'h00;
    pool[1] = 8'hFF;
    pool[2] = 8'h80;
    pool[3] = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      r = 1'($urandom_range(0, 1));
      a = 1'($urandom_range(0, 1));
      v = pool[$urandom_range(0, 3)];
      push(r, a, v, w);
      wr_valid = 1'b0;
      measure_busy(n);
      check("rnd_busy_len", n, last_skip ? SKIP_BUSY : XFER_BUSY);
      check("rnd_factor", rx_factor[{r, a}], m_factor[{r, a}]);
      $display("rnd write %0d right=%0d sel_a=%0d value=%02h skip=%0d busy=%0d",
               i, r, a, v, last_skip, n);
    end

    // Randomized burst that overruns the FIFO
    for (int i = 0; i < 8; i++) begin
      r = 1'($urandom_range(0, 1));
      a = 1'($urandom_range(0, 1));
      v = pool[$urandom_range(0, 3)];
      push(r, a, v, w);
      $display("burst write %0d right=%0d sel_a=%0d value=%02h waited=%0d", i, r, a, v, w);
    end
    wr_valid = 1'b0;
    measure_busy(n);
    check("burst_done", busy, 0);
    check("burst_queue_drained", exp_q.size(), 0);
    check("burst_level", fifo_level, 0);
    for (int i = 0; i < 4; i++) begin
      check("burst_factor", rx_factor[i], m_factor[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
